// File: rtl/result_streamer.sv
// Reads a run of 32-bit result words from memory and streams them out
// MSB-first as bytes on a valid/ready interface, with last and done marking.
module result_streamer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        word_count,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_out,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    STREAM,
    FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q,   adr_d;
  logic [7:0]          rem_q,   rem_d;
  logic [DATA_W-1:0]   word_q,  word_d;
  logic [1:0]          idx_q,   idx_d;
  logic [BYTE_W-1:0]   byte_q,  byte_d;

  // Byte i of a word, most-significant byte first.
  function automatic logic [BYTE_W-1:0] sel_byte(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        i);
    logic [BYTE_W-1:0] b;
    case (i)
      2'd0:    b = w[DATA_W-1            -: BYTE_W];
      2'd1:    b = w[DATA_W-1-BYTE_W     -: BYTE_W];
      2'd2:    b = w[DATA_W-1-2*BYTE_W   -: BYTE_W];
      default: b = w[DATA_W-1-3*BYTE_W   -: BYTE_W];
    endcase
    return b;
  endfunction

  assign mem_adr  = adr_q;
  assign out_data = byte_q;

  // Next-state and output decode for the read/unpack/stream sequence.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    rem_d     = rem_q;
    word_d    = word_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    mem_re    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          adr_d   = base_addr;
          rem_d   = word_count;
          state_d = (word_count == 8'd0) ? FIN : READ;
        end
      end
      READ: begin
        mem_re  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        // The first byte is registered here so it is ready on entry to STREAM.
        word_d  = mem_out;
        idx_d   = 2'd0;
        byte_d  = sel_byte(mem_out, 2'd0);
        adr_d   = adr_q + ADDR_W'(1);
        rem_d   = rem_q - 8'd1;
        state_d = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        out_last  = (idx_q == 2'd3) && (rem_q == 8'd0);
        if (out_ready) begin
          if (idx_q != 2'd3) begin
            idx_d  = idx_q + 2'd1;
            byte_d = sel_byte(word_q, idx_q + 2'd1);
          end else begin
            state_d = (rem_q != 8'd0) ? READ : FIN;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
    end
  end

endmodule
